// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared widths, register-address codes and scoreboard FSM encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int RADDR_W_DEF   = 4;
    localparam int NSRC_DEF      = 3;
    localparam int DEPTH_DEF     = 3;
    localparam int MAX_STALL_DEF = 15;
    localparam int CNT_W         = 16;

    // R0-R7 occupy codes 0-7; special registers follow in the same space
    localparam logic [RADDR_W_DEF-1:0] REG_SP = 4'd8;
    localparam logic [RADDR_W_DEF-1:0] REG_T  = 4'd9;
    localparam logic [RADDR_W_DEF-1:0] REG_IH = 4'd10;

    localparam int                 STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_RUN  = 1'b0;
    localparam logic [STATE_W-1:0] ST_WAIT = 1'b1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/forward_scoreboard_if.sv
// ============================================================================
// Module : forward_scoreboard_if
// Brief  : Issue, lookup, result and stall signals of the forwarding scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface forward_scoreboard_if
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int NSRC    = NSRC_DEF,
    parameter int DEPTH   = DEPTH_DEF
);
    logic                      hold_in;
    logic                      flush;
    logic                      iss_valid;
    logic                      iss_wb_en;
    logic [RADDR_W-1:0]        iss_wb_addr;
    logic [NSRC-1:0]           src_valid;
    logic [NSRC*RADDR_W-1:0]   src_addr;
    logic [DEPTH-1:0]          res_ready;
    logic [DEPTH*DATA_W-1:0]   res_data;
    logic [NSRC-1:0]           fwd_en;
    logic [NSRC*DATA_W-1:0]    fwd_data;
    logic                      stall_out;
    logic [CNT_W-1:0]          stall_cnt;
    logic                      stall_err;

    modport master (
        output hold_in, flush, iss_valid, iss_wb_en, iss_wb_addr,
               src_valid, src_addr, res_ready, res_data,
        input  fwd_en, fwd_data, stall_out, stall_cnt, stall_err
    );

    modport slave (
        input  hold_in, flush, iss_valid, iss_wb_en, iss_wb_addr,
               src_valid, src_addr, res_ready, res_data,
        output fwd_en, fwd_data, stall_out, stall_cnt, stall_err
    );

endinterface

`default_nettype wire

// File: rtl/fwd_lookup.sv
// ============================================================================
// Module : fwd_lookup
// Brief  : Youngest-producer match for one source operand plus result mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_lookup
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  wire logic                    src_valid,
    input  wire logic [RADDR_W-1:0]      src_addr,
    input  wire logic [DEPTH-1:0]        slot_valid,
    input  wire logic [DEPTH*RADDR_W-1:0] slot_addr,
    input  wire logic [DEPTH-1:0]        res_ready,
    input  wire logic [DEPTH*DATA_W-1:0] res_data,
    output logic                         fwd_en,
    output logic [DATA_W-1:0]            fwd_data,
    output logic                         hazard
);

    logic              w_match;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;

    // Scan oldest to youngest so the lowest matching slot is the last write
    always_comb begin
        w_match = 1'b0;
        w_ready = 1'b0;
        w_data  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slot_valid[k] && (slot_addr[k*RADDR_W +: RADDR_W] == src_addr)) begin
                w_match = 1'b1;
                w_ready = res_ready[k];
                w_data  = res_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign fwd_en   = src_valid & w_match & w_ready;
    assign fwd_data = fwd_en ? w_data : '0;
    assign hazard   = src_valid & w_match & ~w_ready;

endmodule

`default_nettype wire

// File: rtl/forward_scoreboard.sv
// ============================================================================
// Module : forward_scoreboard
// Brief  : In-flight destination tracker with operand forwarding, hazard stall
//          FSM, saturating stall counter and consecutive-stall watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module forward_scoreboard
    import cpu_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RADDR_W   = RADDR_W_DEF,
    parameter int NSRC      = NSRC_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int MAX_STALL = MAX_STALL_DEF
) (
    input wire logic            clk,
    input wire logic            rst,
    forward_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0] C_MAX_STALL = CNT_W'(MAX_STALL);

    logic [STATE_W-1:0]       r_state;
    logic [STATE_W-1:0]       w_state_next;
    logic [DEPTH-1:0]         r_slot_valid;
    logic [DEPTH*RADDR_W-1:0] r_slot_addr;
    logic [CNT_W-1:0]         r_stall_cnt;
    logic [CNT_W-1:0]         r_run_cnt;
    logic [CNT_W-1:0]         w_run_next;
    logic                     r_stall_err;
    logic [NSRC-1:0]          w_hazard;
    logic                     w_advance;
    logic                     w_stall;
    logic                     w_new_valid;

    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src
            fwd_lookup #(
                .DATA_W  (DATA_W),
                .RADDR_W (RADDR_W),
                .DEPTH   (DEPTH)
            ) u_lookup (
                .src_valid  (sb.src_valid[i]),
                .src_addr   (sb.src_addr[i*RADDR_W +: RADDR_W]),
                .slot_valid (r_slot_valid),
                .slot_addr  (r_slot_addr),
                .res_ready  (sb.res_ready),
                .res_data   (sb.res_data),
                .fwd_en     (sb.fwd_en[i]),
                .fwd_data   (sb.fwd_data[i*DATA_W +: DATA_W]),
                .hazard     (w_hazard[i])
            );
        end
    endgenerate

    assign w_advance = ~sb.hold_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_advance) begin
            if (sb.flush) begin
                w_state_next = ST_RUN;
            end else if (w_stall) begin
                w_state_next = ST_WAIT;
            end else begin
                w_state_next = ST_RUN;
            end
        end
    end

    // Both states may request a stall; a frozen pipe or a flush suppresses it
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_RUN, ST_WAIT: w_stall = (|w_hazard) & w_advance & ~sb.flush;
            default:         w_stall = 1'b0;
        endcase
    end

    assign w_new_valid = sb.iss_valid & sb.iss_wb_en & ~sb.flush & ~w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_valid <= '0;
            r_slot_addr  <= '0;
        end else if (w_advance) begin
            r_slot_valid <= {r_slot_valid[DEPTH-2:0], w_new_valid};
            r_slot_addr  <= {r_slot_addr[(DEPTH-1)*RADDR_W-1:0], sb.iss_wb_addr};
        end
    end

    always_comb begin
        w_run_next = r_run_cnt;
        if (w_advance) begin
            w_run_next = w_stall ? sat_inc(r_run_cnt) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt   <= '0;
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_run_cnt <= w_run_next;
            if (w_advance && w_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_run_next >= C_MAX_STALL) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    assign sb.stall_out = w_stall;
    assign sb.stall_cnt = r_stall_cnt;
    assign sb.stall_err = r_stall_err;

endmodule

`default_nettype wire

// File: tb/tb_forward_scoreboard.sv
// ============================================================================
// Module : tb_forward_scoreboard
// Brief  : Directed and random checks of forward_scoreboard against a slot-list model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_forward_scoreboard;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NS = 3;
    localparam int DP = 16;
    localparam int MS = 15;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    forward_scoreboard_if #(.DATA_W(DW), .RADDR_W(AW), .NSRC(NS), .DEPTH(DP)) sb ();

    forward_scoreboard #(
        .DATA_W    (DW),
        .RADDR_W   (AW),
        .NSRC      (NS),
        .DEPTH     (DP),
        .MAX_STALL (MS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: list of in-flight destinations, index 0 youngest
    bit m_v [DP];
    int m_a [DP];
    int m_cnt;
    int m_run;
    bit m_err;
    bit e_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DP; k++) begin
            m_v[k] = 1'b0;
            m_a[k] = 0;
        end
        m_cnt   = 0;
        m_run   = 0;
        m_err   = 1'b0;
        e_stall = 1'b0;
    endtask

    task automatic idle();
        sb.hold_in     = 1'b0;
        sb.flush       = 1'b0;
        sb.iss_valid   = 1'b0;
        sb.iss_wb_en   = 1'b0;
        sb.iss_wb_addr = '0;
        sb.src_valid   = '0;
        sb.src_addr    = '0;
        sb.res_ready   = '0;
        sb.res_data    = '0;
    endtask

    function automatic void exp_lookup(input int i, output bit en, output logic [DW-1:0] d,
                                       output bit hz);
        en = 1'b0;
        d  = '0;
        hz = 1'b0;
        if (!sb.src_valid[i]) return;
        for (int k = 0; k < DP; k++) begin
            if (m_v[k] && m_a[k] == int'(sb.src_addr[i*AW +: AW])) begin
                if (sb.res_ready[k]) begin
                    en = 1'b1;
                    d  = sb.res_data[k*DW +: DW];
                end else begin
                    hz = 1'b1;
                end
                return;
            end
        end
    endfunction

    task automatic settle();
        bit              en;
        bit              hz;
        bit              any_hz;
        logic [DW-1:0]   d;
        @(negedge clk);
        any_hz = 1'b0;
        for (int i = 0; i < NS; i++) begin
            exp_lookup(i, en, d, hz);
            any_hz |= hz;
            chk($sformatf("fwd_en[%0d]", i), 32'(sb.fwd_en[i]), 32'(en));
            chk($sformatf("fwd_data[%0d]", i), 32'(sb.fwd_data[i*DW +: DW]), 32'(d));
        end
        e_stall = any_hz && !sb.hold_in && !sb.flush;
        chk("stall_out", 32'(sb.stall_out), 32'(e_stall));
        chk("stall_cnt", 32'(sb.stall_cnt), 32'(m_cnt));
        chk("stall_err", 32'(sb.stall_err), 32'(m_err));
    endtask

    task automatic tick();
        if (!sb.hold_in) begin
            for (int k = DP - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1];
                m_a[k] = m_a[k-1];
            end
            m_v[0] = sb.iss_valid && sb.iss_wb_en && !sb.flush && !e_stall;
            m_a[0] = int'(sb.iss_wb_addr);
            if (e_stall) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_run < 65535) m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run >= MS) m_err = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic issue(input logic [AW-1:0] a);
        idle();
        sb.iss_valid   = 1'b1;
        sb.iss_wb_en   = 1'b1;
        sb.iss_wb_addr = a;
        settle();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state with live lookups
        sb.src_valid = 3'b111;
        sb.src_addr  = 12'h321;
        sb.res_ready = '1;
        settle();
        chk("rst_stall_out", 32'(sb.stall_out), 32'd0);
        chk("rst_fwd_en", 32'(sb.fwd_en), 32'd0);
        chk("rst_stall_cnt", 32'(sb.stall_cnt), 32'd0);
        tick();

        // Forward from youngest slot one cycle after issue
        do_reset();
        issue(4'd3);
        idle();
        sb.src_valid[0]     = 1'b1;
        sb.src_addr[3:0]    = 4'd3;
        sb.res_ready[0]     = 1'b1;
        sb.res_data[15:0]   = 16'h1234;
        settle();
        chk("r034_en", 32'(sb.fwd_en[0]), 32'd1);
        chk("r034_data", 32'(sb.fwd_data[15:0]), 32'h1234);
        chk("r034_stall", 32'(sb.stall_out), 32'd0);
        tick();

        // Youngest of two producers wins
        do_reset();
        issue(4'd2);
        issue(4'd2);
        idle();
        sb.src_valid[1]     = 1'b1;
        sb.src_addr[7:4]    = 4'd2;
        sb.res_ready[1:0]   = 2'b11;
        sb.res_data[15:0]   = 16'h0005;
        sb.res_data[31:16]  = 16'h0009;
        settle();
        chk("r035_data", 32'(sb.fwd_data[31:16]), 32'h0005);
        tick();

        // Load-use stall, bubble, then forward from slot1
        do_reset();
        issue(4'd4);
        idle();
        sb.iss_valid    = 1'b1;
        sb.iss_wb_en    = 1'b1;
        sb.iss_wb_addr  = 4'd5;
        sb.src_valid    = 3'b001;
        sb.src_addr     = 12'h004;
        settle();
        chk("r036_stall", 32'(sb.stall_out), 32'd1);
        tick();
        idle();
        sb.src_valid       = 3'b011;
        sb.src_addr        = 12'h054;
        sb.res_ready       = '1;
        sb.res_data[15:0]  = 16'h5555;
        sb.res_data[31:16] = 16'h00AA;
        settle();
        chk("r036_data", 32'(sb.fwd_data[15:0]), 32'h00AA);
        chk("r036_bubble", 32'(sb.fwd_en[1]), 32'd0);
        chk("r036_nostall", 32'(sb.stall_out), 32'd0);
        chk("r036_cnt", 32'(sb.stall_cnt), 32'd1);
        tick();

        // Watchdog after MS consecutive stalled advances, sticky afterwards
        do_reset();
        issue(4'd6);
        idle();
        sb.src_valid = 3'b001;
        sb.src_addr  = 12'h006;
        for (int n = 1; n <= MS; n++) begin
            settle();
            chk("r037_stall", 32'(sb.stall_out), 32'd1);
            tick();
            if (n == MS - 1) chk("r037_err_early", 32'(sb.stall_err), 32'd0);
        end
        chk("r037_err", 32'(sb.stall_err), 32'd1);
        chk("r037_cnt", 32'(sb.stall_cnt), 32'(MS));
        idle();
        settle();
        tick();
        chk("r037_err_sticky", 32'(sb.stall_err), 32'd1);

        // Hold freezes slots and masks the stall
        do_reset();
        issue(4'd7);
        idle();
        sb.src_valid = 3'b001;
        sb.src_addr  = 12'h007;
        sb.hold_in   = 1'b1;
        repeat (3) begin
            settle();
            chk("r038_stall", 32'(sb.stall_out), 32'd0);
            tick();
        end
        chk("r038_cnt", 32'(sb.stall_cnt), 32'd0);
        sb.hold_in         = 1'b0;
        sb.res_ready[0]    = 1'b1;
        sb.res_data[15:0]  = 16'h0777;
        settle();
        chk("r038_frozen_en", 32'(sb.fwd_en[0]), 32'd1);
        chk("r038_frozen_data", 32'(sb.fwd_data[15:0]), 32'h0777);
        tick();

        // Flush beats hazard; then asynchronous reset mid-WAIT
        do_reset();
        issue(4'd1);
        idle();
        sb.src_valid = 3'b001;
        sb.src_addr  = 12'h001;
        settle();
        chk("r039_stall", 32'(sb.stall_out), 32'd1);
        tick();
        sb.flush       = 1'b1;
        sb.iss_valid   = 1'b1;
        sb.iss_wb_en   = 1'b1;
        sb.iss_wb_addr = 4'd9;
        settle();
        chk("r039_flush_wins", 32'(sb.stall_out), 32'd0);
        tick();
        idle();
        sb.src_valid = 3'b011;
        sb.src_addr  = 12'h091;
        sb.res_ready = 16'hFFFB;
        settle();
        chk("r039_bubble", 32'(sb.fwd_en[1]), 32'd0);
        chk("r039_rerun", 32'(sb.stall_out), 32'd1);
        tick();
        sb.res_ready = 16'hFFF7;
        settle();
        chk("r039_wait_stall", 32'(sb.stall_out), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("r039_rst_stall", 32'(sb.stall_out), 32'd0);
        chk("r039_rst_en", 32'(sb.fwd_en), 32'd0);
        chk("r039_rst_data", 32'(sb.fwd_data[31:0]), 32'd0);
        chk("r039_rst_cnt", 32'(sb.stall_cnt), 32'd0);
        chk("r039_rst_err", 32'(sb.stall_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            sb.hold_in     = ($urandom_range(0, 7) == 0);
            sb.flush       = ($urandom_range(0, 9) == 0);
            sb.iss_valid   = 1'($urandom);
            sb.iss_wb_en   = ($urandom_range(0, 3) != 0);
            sb.iss_wb_addr = AW'($urandom_range(0, 7));
            sb.src_valid   = NS'($urandom);
            for (int i = 0; i < NS; i++) begin
                sb.src_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            end
            sb.res_ready = DP'($urandom);
            for (int k = 0; k < DP; k++) begin
                sb.res_data[k*DW +: DW] = DW'($urandom);
            end
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
